// File: rtl/screen_pkg.sv
// Screen geometry, coordinate/color/address widths and the queued pixel record
// shared by the renderers and the framebuffer write path.
package screen_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  localparam int X_W     = 9;
  localparam int Y_W     = 8;
  localparam int COLOR_W = 3;
  localparam int ADDR_W  = 17;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
  } pixel_entry_t;

endpackage

// File: rtl/pixel_fifo.sv
// Generic synchronous FIFO with a combinational head; push and pop may coincide
// at any occupancy, including full.
module pixel_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage is cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/fb_write_queue.sv
// Clips renderer pixels to the screen, converts them to linear framebuffer
// addresses and queues them until the scan arbiter grants the write port.
module fb_write_queue #(
  parameter int DEPTH   = 8,
  parameter int X_W     = screen_pkg::X_W,
  parameter int Y_W     = screen_pkg::Y_W,
  parameter int COLOR_W = screen_pkg::COLOR_W,
  parameter int ADDR_W  = screen_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  input  logic [X_W-1:0]     in_x,
  input  logic [Y_W-1:0]     in_y,
  input  logic [COLOR_W-1:0] in_color,
  output logic               in_ready,
  input  logic               fb_grant,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               idle,
  output logic [7:0]         dropped
);
  import screen_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] x_ext;
  logic [ADDR_W-1:0] y_ext;
  logic [ADDR_W-1:0] addr_calc;
  logic              in_range;
  logic              accept;

  pixel_entry_t      intake_entry;
  logic              intake_valid;
  pixel_entry_t      head;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W:0]    occupancy;

  assign in_range = (in_x < X_W'(SCREEN_W)) && (in_y < Y_W'(SCREEN_H));
  assign accept   = in_valid && in_ready;

  // y*320 + x as y*256 + y*64 + x, at full address width.
  assign x_ext     = ADDR_W'(in_x);
  assign y_ext     = ADDR_W'(in_y);
  assign addr_calc = (y_ext << 8) + (y_ext << 6) + x_ext;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      intake_valid <= 1'b0;
      intake_entry <= '0;
    end else begin
      intake_valid <= accept && in_range;
      if (accept && in_range) begin
        intake_entry.addr  <= addr_calc;
        intake_entry.color <= in_color;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dropped <= '0;
    end else if (accept && !in_range && dropped != 8'hFF) begin
      dropped <= dropped + 8'd1;
    end
  end

  // Room is guaranteed by in_ready, so the intake entry never has to wait.
  pixel_fifo #(
    .WIDTH($bits(pixel_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (intake_valid),
    .wdata (intake_entry),
    .pop   (fb_we),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, intake_valid};
  assign in_ready  = !fifo_full && (occupancy < (CNT_W+1)'(DEPTH));

  assign fb_we   = !fifo_empty && fb_grant;
  assign fb_addr = head.addr;
  assign fb_data = head.color;
  assign idle    = !intake_valid && fifo_empty;

endmodule

// File: tb/tb_fb_write_queue.sv
// Bench for fb_write_queue: vector table for single pixels plus scoreboarded
// burst, grant-toggle, reset and saturation sequences.
module tb_fb_write_queue;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [8:0]  in_x = '0;
  logic [7:0]  in_y = '0;
  logic [2:0]  in_color = '0;
  logic        in_ready;
  logic        fb_grant = 1'b0;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [2:0]  fb_data;
  logic        idle;
  logic [7:0]  dropped;

  fb_write_queue dut (
    .clk     (clk),
    .resetn  (resetn),
    .in_valid(in_valid),
    .in_x    (in_x),
    .in_y    (in_y),
    .in_color(in_color),
    .in_ready(in_ready),
    .fb_grant(fb_grant),
    .fb_we   (fb_we),
    .fb_addr (fb_addr),
    .fb_data (fb_data),
    .idle    (idle),
    .dropped (dropped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int writes = 0;
  int drop_model = 0;

  typedef struct {
    int addr;
    int color;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int x;
    int y;
    int color;
    int clip;
    int addr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_accept(input int x, input int y, input int c);
    exp_t e;
    if (x < 320 && y < 240) begin
      e.addr  = y * 320 + x;
      e.color = c;
      exp_q.push_back(e);
    end else if (drop_model < 255) begin
      drop_model++;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive_pixel(input int x, input int y, input int c, output int stalls);
    logic ok;
    stalls   = 0;
    in_valid = 1'b1;
    in_x     = x[8:0];
    in_y     = y[7:0];
    in_color = c[2:0];
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      if (ok) begin
        model_accept(x, y, c);
        #1;
        in_valid = 1'b0;
        return;
      end
      stalls++;
    end
    checks++;
    failures++;
    $display("FAIL accept_timeout x=%0d y=%0d never accepted", x, y);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (idle && exp_q.size() == 0) break;
    end
    check({name, "_idle"}, idle, 1);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write must match the oldest accepted in-range pixel.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn) begin
      if (fb_we) begin
        writes++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write actual_addr=%0d required=no write", fb_addr);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", fb_addr, e.addr);
          check("write_data", fb_data, e.color);
        end
      end
      check("dropped", dropped, drop_model);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   st;
    int   tot;
    int   w0;

    vecs = '{
      '{5,   2,   3, 0, 645},
      '{319, 239, 7, 0, 76799},
      '{0,   0,   1, 0, 0},
      '{320, 0,   2, 1, 0},
      '{0,   240, 4, 1, 0},
      '{100, 100, 6, 0, 32100},
      '{0,   1,   5, 0, 320},
      '{319, 0,   2, 0, 319},
      '{0,   239, 1, 0, 76480}
    };

    fb_grant = 1'b1;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    check("rst_idle", idle, 1);
    check("rst_dropped", dropped, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Single pixels with grant high: exact latency, address and one pulse.
    foreach (vecs[i]) begin
      drive_pixel(vecs[i].x, vecs[i].y, vecs[i].color, st);
      check($sformatf("vec%0d_stall", i), st, 0);
      @(negedge clk);
      check($sformatf("vec%0d_we_early", i), fb_we, 0);
      @(negedge clk);
      check($sformatf("vec%0d_we", i), fb_we, (vecs[i].clip != 0) ? 0 : 1);
      if (vecs[i].clip == 0) begin
        check($sformatf("vec%0d_addr", i), fb_addr, vecs[i].addr);
        check($sformatf("vec%0d_data", i), fb_data, vecs[i].color);
      end
      @(negedge clk);
      check($sformatf("vec%0d_we_after", i), fb_we, 0);
      check($sformatf("vec%0d_idle", i), idle, 1);
      @(posedge clk);
      #1;
    end
    check("dropped_after_table", dropped, 2);

    // Sustained one pixel per cycle with grant held.
    w0 = writes;
    tot = 0;
    for (int i = 0; i < 10; i++) begin
      drive_pixel(i * 31, i + 10, i % 8, st);
      tot += st;
    end
    check("stream_stalls", tot, 0);
    wait_idle("stream");
    check("stream_writes", writes - w0, 10);

    // Burst of 20 with grant low: ready drops after 8, then drains in order.
    fb_grant = 1'b0;
    w0 = writes;
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      drive_pixel(i * 7 + 1, i * 2 + 3, i % 8, st);
      tot += st;
    end
    check("burst_first8_stalls", tot, 0);
    @(negedge clk);
    check("burst_ready_drop", in_ready, 0);
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 8; i < 20; i++) begin
          drive_pixel(i * 13, 239 - i, i % 8, st);
        end
      end
      begin
        repeat (4) @(negedge clk);
        check("burst_held_we", fb_we, 0);
        check("burst_held_ready", in_ready, 0);
        @(posedge clk);
        #1;
        fb_grant = 1'b1;
      end
    join
    wait_idle("burst");
    check("burst_writes", writes - w0, 20);

    // Grant toggling against a continuous stream: full with push+pop together.
    w0 = writes;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          drive_pixel(300 - i * 11, i * 9, (i + 3) % 8, st);
        end
      end
      begin
        for (int k = 0; k < 80; k++) begin
          fb_grant = k[0];
          @(posedge clk);
          #1;
        end
        fb_grant = 1'b1;
      end
    join
    wait_idle("toggle");
    check("toggle_writes", writes - w0, 24);

    // Reset with five pixels queued: all discarded.
    fb_grant = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_pixel(50 + i, 60 + i, i + 1, st);
    end
    repeat (2) @(posedge clk);
    #1;
    fb_grant = 1'b1;
    resetn   = 1'b0;
    #1;
    check("midrst_fb_we", fb_we, 0);
    check("midrst_idle", idle, 1);
    check("midrst_dropped", dropped, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_fb_addr", fb_addr, 0);
    exp_q.delete();
    drop_model = 0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    w0 = writes;
    drive_pixel(7, 7, 5, st);
    wait_idle("postrst");
    check("postrst_writes", writes - w0, 1);

    // Saturation of the drop counter; nothing reaches the framebuffer.
    w0 = writes;
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) drive_pixel(320 + (i % 192), i % 256, i % 8, st);
      else            drive_pixel(i % 320, 240 + (i % 16), i % 8, st);
    end
    @(negedge clk);
    check("sat_dropped", dropped, 255);
    check("sat_writes", writes - w0, 0);
    check("sat_idle", idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
